// File: rtl/ifmap_bank_scheduler.sv
// Ifmap bank scheduler: DMA load requests, in-order hand-off of full banks to the PEs, and bank recycling on NOC frees.
// Optional IFMAP_SCHED_PERF_EN adds the stall_cycles counter port.

module ifmap_bank_slot (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       set_loading,
  input  logic       set_full,
  input  logic       set_in_use,
  input  logic       set_free,
  output logic [1:0] st
);
  localparam logic [1:0] B_FREE = 2'd0, B_LOADING = 2'd1, B_FULL = 2'd2, B_IN_USE = 2'd3;

  // Each set is qualified by a distinct current state, so at most one fires per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           st <= B_FREE;
    else if (set_loading) st <= B_LOADING;
    else if (set_full)    st <= B_FULL;
    else if (set_in_use)  st <= B_IN_USE;
    else if (set_free)    st <= B_FREE;
  end
endmodule

module ifmap_bank_scheduler #(
  parameter int NUM_BANKS = 2,
  parameter int BATCH_L1  = 8,
  parameter int BATCH_L2  = 1,
  parameter int BATCH_L3  = 16,
  localparam int BANK_W   = $clog2(NUM_BANKS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        layer_type_in,
  output logic              load_req_valid,
  input  logic              load_req_ready,
  output logic [BANK_W-1:0] load_req_bank,
  output logic [4:0]        load_req_batch,
  input  logic              load_done,
  input  logic [BANK_W-1:0] load_done_bank,
  output logic              pe_bank_valid,
  output logic [BANK_W-1:0] pe_bank_id,
  input  logic              pe_bank_take,
  input  logic              free_ifmap_buffer,
  output logic              busy,
  output logic              layer_done,
  output logic              err
`ifdef IFMAP_SCHED_PERF_EN
  ,output logic [15:0]      stall_cycles
`endif
);
  localparam logic [1:0] B_FREE = 2'd0, B_LOADING = 2'd1, B_FULL = 2'd2, B_IN_USE = 2'd3;

  typedef enum logic {S_IDLE, S_RUN} state_t;
  state_t state, state_nxt;

  logic [BANK_W-1:0] load_ptr, read_ptr, free_ptr, load_ptr_n;
  logic [4:0] issued, freed, total, issued_n, freed_n, total_sel;
  logic req_vld, req_nxt;
  logic layer_fin, err_nxt;
  logic [NUM_BANKS-1:0][1:0] bank_st;
  logic [NUM_BANKS-1:0] set_loading, set_full, set_in_use, set_free;

  logic accept, done_ok, pe_vld, take_ok, free_ok, start_ok;

  assign accept   = req_vld & load_req_ready;
  assign done_ok  = load_done & (bank_st[load_done_bank] == B_LOADING);
  assign pe_vld   = (bank_st[read_ptr] == B_FULL);
  assign take_ok  = pe_bank_take & pe_vld;
  assign free_ok  = free_ifmap_buffer & (bank_st[free_ptr] == B_IN_USE);
  assign start_ok = start & (state == S_IDLE) & (layer_type_in != 2'd3);

  assign issued_n   = issued + 5'(accept);
  assign load_ptr_n = load_ptr + BANK_W'(accept);
  assign freed_n    = freed + 5'(free_ok);

  always_comb begin
    total_sel = 5'(BATCH_L1);
    case (layer_type_in)
      2'd1:    total_sel = 5'(BATCH_L2);
      2'd2:    total_sel = 5'(BATCH_L3);
      default: total_sel = 5'(BATCH_L1);
    endcase
  end

  genvar b;
  generate
    for (b = 0; b < NUM_BANKS; b++) begin : g_bank
      assign set_loading[b] = accept  & (load_ptr       == BANK_W'(b));
      assign set_full[b]    = done_ok & (load_done_bank == BANK_W'(b));
      assign set_in_use[b]  = take_ok & (read_ptr       == BANK_W'(b));
      assign set_free[b]    = free_ok & (free_ptr       == BANK_W'(b));
      ifmap_bank_slot u_slot (
        .clk         (clk),
        .rst_n       (rst_n),
        .set_loading (set_loading[b]),
        .set_full    (set_full[b]),
        .set_in_use  (set_in_use[b]),
        .set_free    (set_free[b]),
        .st          (bank_st[b])
      );
    end
  endgenerate

  always_comb begin
    state_nxt = state;
    layer_fin = 1'b0;
    case (state)
      S_IDLE: if (start_ok) state_nxt = S_RUN;
      S_RUN: begin
        if (free_ok && (freed_n == total)) begin
          state_nxt = S_IDLE;
          layer_fin = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Bank states are pre-update, so a bank freed this cycle is only requestable a cycle later.
  always_comb begin
    if (req_vld && !load_req_ready) req_nxt = 1'b1;
    else req_nxt = (state == S_RUN) && (issued_n < total) && (bank_st[load_ptr_n] == B_FREE);
  end

  always_comb begin
    err_nxt = (start & ((state == S_RUN) | (layer_type_in == 2'd3)))
            | (load_done & ~done_ok)
            | (pe_bank_take & ~pe_vld)
            | (free_ifmap_buffer & ~free_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      load_ptr   <= '0;
      read_ptr   <= '0;
      free_ptr   <= '0;
      issued     <= '0;
      freed      <= '0;
      total      <= '0;
      req_vld    <= 1'b0;
      layer_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_nxt;
      req_vld    <= req_nxt;
      layer_done <= layer_fin;
      err        <= err_nxt;
      if (start_ok) begin
        total    <= total_sel;
        load_ptr <= '0;
        read_ptr <= '0;
        free_ptr <= '0;
        issued   <= '0;
        freed    <= '0;
      end else begin
        load_ptr <= load_ptr_n;
        issued   <= issued_n;
        freed    <= freed_n;
        if (take_ok) read_ptr <= read_ptr + 1'b1;
        if (free_ok) free_ptr <= free_ptr + 1'b1;
      end
    end
  end

`ifdef IFMAP_SCHED_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cycles <= '0;
    else if (start_ok) stall_cycles <= '0;
    else if ((state == S_RUN) && !pe_vld && (issued != 5'd0) && (stall_cycles != 16'hFFFF))
      stall_cycles <= stall_cycles + 16'd1;
  end
`endif

  assign load_req_valid = req_vld;
  assign load_req_bank  = req_vld ? load_ptr : '0;
  assign load_req_batch = req_vld ? issued : '0;
  assign pe_bank_valid  = pe_vld;
  assign pe_bank_id     = pe_vld ? read_ptr : '0;
  assign busy           = (state == S_RUN);
endmodule

// File: tb/tb_ifmap_bank_scheduler.sv
// Directed bench for ifmap_bank_scheduler: a LAYER2 vector table plus hand-written multi-cycle sequences.
module tb_ifmap_bank_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [1:0] layer_type_in = 2'd0;
  logic load_req_valid, load_req_ready = 1'b0;
  logic [0:0] load_req_bank;
  logic [4:0] load_req_batch;
  logic load_done = 1'b0;
  logic [0:0] load_done_bank = 1'b0;
  logic pe_bank_valid;
  logic [0:0] pe_bank_id;
  logic pe_bank_take = 1'b0, free_ifmap_buffer = 1'b0;
  logic busy, layer_done, err;

  ifmap_bank_scheduler dut (
    .clk(clk), .rst_n(rst_n), .start(start), .layer_type_in(layer_type_in),
    .load_req_valid(load_req_valid), .load_req_ready(load_req_ready),
    .load_req_bank(load_req_bank), .load_req_batch(load_req_batch),
    .load_done(load_done), .load_done_bank(load_done_bank),
    .pe_bank_valid(pe_bank_valid), .pe_bank_id(pe_bank_id), .pe_bank_take(pe_bank_take),
    .free_ifmap_buffer(free_ifmap_buffer), .busy(busy), .layer_done(layer_done), .err(err)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // {valid, bank, batch[4:0], pe_valid, pe_id, busy, layer_done, err}
  function automatic logic [11:0] obs();
    return {load_req_valid, load_req_bank, load_req_batch, pe_bank_valid, pe_bank_id, busy, layer_done, err};
  endfunction

  function automatic logic [11:0] ex(input logic v, input logic bk, input logic [4:0] bt, input logic pv,
                                     input logic pid, input logic bsy, input logic ld, input logic er);
    return {v, bk, bt, pv, pid, bsy, ld, er};
  endfunction

  typedef struct {
    logic st; logic [1:0] ty; logic rdy; logic dn; logic dnb; logic tk; logic fr;
    logic [11:0] exp;
  } vec_t;

  function automatic vec_t mkv(input logic st, input logic [1:0] ty, input logic rdy, input logic dn,
                               input logic dnb, input logic tk, input logic fr, input logic [11:0] e);
    vec_t r;
    r.st = st; r.ty = ty; r.rdy = rdy; r.dn = dn; r.dnb = dnb; r.tk = tk; r.fr = fr; r.exp = e;
    return r;
  endfunction

  // Reactive DMA/PE/NOC model state
  int acc = 0, tk_n = 0, fr_n = 0, inuse = 0, ld_n = 0, err_n = 0;
  logic pend = 1'b0;
  logic [0:0] pend_b = 1'b0;

  task automatic react(input int cycles, input bit do_free);
    for (int i = 0; i < cycles; i++) begin
      load_done = pend;
      load_done_bank = pend_b;
      pend = 1'b0;
      if (load_req_valid) begin
        chk("l1_req_bank", int'(load_req_bank), acc % 2);
        chk("l1_req_batch", int'(load_req_batch), acc);
        acc++;
        pend = 1'b1;
        pend_b = load_req_bank;
      end
      free_ifmap_buffer = do_free && (inuse > 0) && (i % 3 == 0);
      if (free_ifmap_buffer) begin fr_n++; inuse--; end
      pe_bank_take = pe_bank_valid;
      if (pe_bank_take) begin tk_n++; inuse++; end
      if (layer_done) ld_n++;
      if (err) err_n++;
      step();
    end
    load_done = 1'b0; pe_bank_take = 1'b0; free_ifmap_buffer = 1'b0;
  endtask

  vec_t tbl[14];

  initial begin
    // LAYER2, one batch: request at +2, done 3 after accept, take 1 after valid, free 5 later
    tbl[0]  = mkv(1, 2'd1, 1, 0, 0, 0, 0, ex(0, 0, 5'd0, 0, 0, 1, 0, 0));
    tbl[1]  = mkv(0, 2'd1, 1, 0, 0, 0, 0, ex(1, 0, 5'd0, 0, 0, 1, 0, 0));
    tbl[2]  = mkv(0, 2'd1, 1, 0, 0, 0, 0, ex(0, 0, 5'd0, 0, 0, 1, 0, 0));
    tbl[3]  = mkv(0, 2'd1, 1, 0, 0, 0, 0, ex(0, 0, 5'd0, 0, 0, 1, 0, 0));
    tbl[4]  = mkv(0, 2'd1, 1, 0, 0, 0, 0, ex(0, 0, 5'd0, 0, 0, 1, 0, 0));
    tbl[5]  = mkv(0, 2'd1, 1, 1, 0, 0, 0, ex(0, 0, 5'd0, 1, 0, 1, 0, 0));
    tbl[6]  = mkv(0, 2'd1, 1, 0, 0, 0, 0, ex(0, 0, 5'd0, 1, 0, 1, 0, 0));
    tbl[7]  = mkv(0, 2'd1, 1, 0, 0, 1, 0, ex(0, 0, 5'd0, 0, 0, 1, 0, 0));
    tbl[8]  = mkv(0, 2'd1, 1, 0, 0, 0, 0, ex(0, 0, 5'd0, 0, 0, 1, 0, 0));
    tbl[9]  = mkv(0, 2'd1, 1, 0, 0, 0, 0, ex(0, 0, 5'd0, 0, 0, 1, 0, 0));
    tbl[10] = mkv(0, 2'd1, 1, 0, 0, 0, 0, ex(0, 0, 5'd0, 0, 0, 1, 0, 0));
    tbl[11] = mkv(0, 2'd1, 1, 0, 0, 0, 0, ex(0, 0, 5'd0, 0, 0, 1, 0, 0));
    tbl[12] = mkv(0, 2'd1, 1, 0, 0, 0, 1, ex(0, 0, 5'd0, 0, 0, 0, 1, 0));
    tbl[13] = mkv(0, 2'd1, 1, 0, 0, 0, 0, ex(0, 0, 5'd0, 0, 0, 0, 0, 0));

    step(); step();
    chk("reset_outputs", int'(obs()), 0);
    rst_n = 1'b1;
    step();

    for (int k = 0; k < 14; k++) begin
      start = tbl[k].st; layer_type_in = tbl[k].ty; load_req_ready = tbl[k].rdy;
      load_done = tbl[k].dn; load_done_bank = tbl[k].dnb;
      pe_bank_take = tbl[k].tk; free_ifmap_buffer = tbl[k].fr;
      step();
      chk($sformatf("l2_vec%0d", k), int'(obs()), int'(tbl[k].exp));
    end
    start = 0; load_done = 0; pe_bank_take = 0; free_ifmap_buffer = 0; load_req_ready = 0;

    // Illegal layer type
    start = 1; layer_type_in = 2'd3;
    step();
    start = 0;
    chk("ty3_err", int'(err), 1);
    chk("ty3_busy", int'(busy), 0);
    step();
    chk("ty3_err_clear", int'(err), 0);

    // LAYER1, DMA always ready, PE frees withheld then released
    load_req_ready = 1; layer_type_in = 2'd0; start = 1;
    step();
    start = 0;
    react(30, 1'b0);
    chk("l1_stall_reqs", acc, 2);
    chk("l1_stall_takes", tk_n, 2);
    chk("l1_stall_pe_valid", int'(pe_bank_valid), 0);
    chk("l1_stall_req_valid", int'(load_req_valid), 0);
    react(120, 1'b1);
    chk("l1_total_reqs", acc, 8);
    chk("l1_total_frees", fr_n, 8);
    chk("l1_layer_done_cnt", ld_n, 1);
    chk("l1_err_cnt", err_n, 0);
    chk("l1_busy_after", int'(busy), 0);
    load_req_ready = 0;

    // LAYER3 with DMA back-pressure
    layer_type_in = 2'd2; start = 1;
    step();
    start = 0;
    step();
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("hold_req%0d", i), int'({load_req_valid, load_req_bank, load_req_batch}), {1'b1, 1'b0, 5'd0});
      step();
    end
    load_req_ready = 1;
    step();
    load_req_ready = 0;
    chk("accept0_next_req", int'({load_req_valid, load_req_bank, load_req_batch}), {1'b1, 1'b1, 5'd1});
    load_req_ready = 1;
    step();
    load_req_ready = 0;
    chk("both_loading_no_req", int'(load_req_valid), 0);

    // Out-of-order fills
    load_done = 1; load_done_bank = 1'b1;
    step();
    load_done = 0;
    chk("ooo_wait_bank0", int'(pe_bank_valid), 0);
    load_done = 1; load_done_bank = 1'b0;
    step();
    load_done = 0;
    chk("ooo_pe0", int'({pe_bank_valid, pe_bank_id}), 2);
    pe_bank_take = 1;
    step();
    pe_bank_take = 0;
    chk("ooo_pe1", int'({pe_bank_valid, pe_bank_id}), 3);
    pe_bank_take = 1;
    step();
    pe_bank_take = 0;
    chk("ooo_pe_empty", int'(pe_bank_valid), 0);

    // Protocol errors during RUN
    start = 1; layer_type_in = 2'd0;
    step();
    start = 0;
    chk("run_start_err", int'({err, busy}), 3);
    step();
    chk("run_start_err_clear", int'(err), 0);
    free_ifmap_buffer = 1;
    step();
    free_ifmap_buffer = 0;
    chk("free0_ok", int'(err), 0);
    step();
    chk("req_after_free", int'({load_req_valid, load_req_bank, load_req_batch}), {1'b1, 1'b0, 5'd2});
    free_ifmap_buffer = 1;
    step();
    free_ifmap_buffer = 0;
    chk("free1_ok", int'(err), 0);
    free_ifmap_buffer = 1;
    step();
    free_ifmap_buffer = 0;
    chk("free_none_err", int'({err, busy}), 3);
    pe_bank_take = 1;
    step();
    pe_bank_take = 0;
    chk("take_novalid_err", int'(err), 1);

    // Asynchronous reset mid LAYER3 run
    #2 rst_n = 0;
    #1;
    chk("async_reset_outputs", int'(obs()), 0);
    step();
    rst_n = 1;
    step();
    load_done = 1; load_done_bank = 1'b1;
    step();
    load_done = 0;
    chk("done_idle_err", int'(err), 1);
    layer_type_in = 2'd2; start = 1;
    step();
    start = 0;
    step();
    chk("restart_batch0", int'(obs()), int'(ex(1, 0, 5'd0, 0, 0, 1, 0, 0)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
